// File: rtl/flash_port_arbiter.sv
// Arbitrates the Ibex instruction and LSU ports onto one read-only Avalon-MM
// flash port. Only one transaction is in flight at a time.
module flash_port_arbiter #(
    parameter logic [31:0] FLASH_BASE = 32'h0000_0000,
    parameter logic [31:0] FLASH_MASK = 32'h0000_FFFF,
    parameter bit          BYTE_SWAP  = 1'b1
) (
    input  logic        IO_CLK,
    input  logic        IO_RST_N,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_q;
    logic        owner_q;
    logic        last_data_q;
    logic        avm_read_q;
    logic [31:0] avm_addr_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        i_err_q;
    logic        d_err_q;

    logic        any_req;
    logic        sel_data;
    logic [31:0] sel_addr;
    logic        in_win;
    logic        bad;
    logic        idle_err;
    logic        cmd_acc;
    logic [31:0] word_addr;
    logic [31:0] rd_word;

    // owner_q / sel_data: 1 = LSU port, 0 = fetch port
    assign any_req   = instr_req_i | data_req_i;
    assign sel_data  = data_req_i & (~instr_req_i | ~last_data_q);
    assign sel_addr  = sel_data ? data_addr_i : instr_addr_i;
    assign in_win    = (sel_addr & ~FLASH_MASK) == FLASH_BASE;
    assign bad       = ~in_win | (sel_data & data_we_i);
    assign idle_err  = (state_q == IDLE) & any_req & bad;
    assign cmd_acc   = (state_q == CMD) & ~avm_waitrequest_i;
    assign word_addr = (sel_addr - FLASH_BASE) >> 2;

    assign rd_word = BYTE_SWAP ?
        {avm_readdata_i[7:0], avm_readdata_i[15:8],
         avm_readdata_i[23:16], avm_readdata_i[31:24]} :
        avm_readdata_i;

    assign instr_gnt_o = (idle_err & ~sel_data) |
                         (cmd_acc & ~owner_q & instr_req_i);
    assign data_gnt_o  = (idle_err & sel_data) |
                         (cmd_acc & owner_q & data_req_i);

    assign instr_rvalid_o = (state_q == RESP) & ~owner_q;
    assign data_rvalid_o  = (state_q == RESP) & owner_q;
    assign instr_rdata_o  = i_rdata_q;
    assign instr_err_o    = i_err_q;
    assign data_rdata_o   = d_rdata_q;
    assign data_err_o     = d_err_q;
    assign avm_read_o     = avm_read_q;
    assign avm_address_o  = avm_addr_q;

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_data_q <= 1'b1;
            avm_read_q  <= 1'b0;
            avm_addr_q  <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= sel_data;
                        if (bad) begin
                            state_q <= RESP;
                            if (sel_data) begin
                                d_rdata_q <= '0;
                                d_err_q   <= 1'b1;
                            end else begin
                                i_rdata_q <= '0;
                                i_err_q   <= 1'b1;
                            end
                        end else begin
                            state_q    <= CMD;
                            avm_read_q <= 1'b1;
                            avm_addr_q <= word_addr;
                        end
                    end
                end
                CMD: begin
                    // command stays on the bus until the slave takes it
                    if (!avm_waitrequest_i) begin
                        avm_read_q <= 1'b0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (avm_readdatavalid_i) begin
                        state_q <= RESP;
                        if (owner_q) begin
                            d_rdata_q <= rd_word;
                            d_err_q   <= 1'b0;
                        end else begin
                            i_rdata_q <= rd_word;
                            i_err_q   <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    last_data_q <= owner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed cycle-table bench for flash_port_arbiter plus a hand-written
// mid-transaction reset sequence.
module tb_flash_port_arbiter;

    logic        IO_CLK = 1'b0;
    logic        IO_RST_N;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
    logic        avm_readdatavalid_i;

    flash_port_arbiter dut (
        .IO_CLK              (IO_CLK),
        .IO_RST_N            (IO_RST_N),
        .instr_req_i         (instr_req_i),
        .instr_addr_i        (instr_addr_i),
        .instr_gnt_o         (instr_gnt_o),
        .instr_rvalid_o      (instr_rvalid_o),
        .instr_rdata_o       (instr_rdata_o),
        .instr_err_o         (instr_err_o),
        .data_req_i          (data_req_i),
        .data_addr_i         (data_addr_i),
        .data_we_i           (data_we_i),
        .data_gnt_o          (data_gnt_o),
        .data_rvalid_o       (data_rvalid_o),
        .data_rdata_o        (data_rdata_o),
        .data_err_o          (data_err_o),
        .avm_address_o       (avm_address_o),
        .avm_read_o          (avm_read_o),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdata_i      (avm_readdata_i),
        .avm_readdatavalid_i (avm_readdatavalid_i)
    );

    always #5 IO_CLK = ~IO_CLK;

    typedef struct {
        logic         ir;
        logic [31:0]  ia;
        logic         dr;
        logic [31:0]  da;
        logic         dw;
        logic         wr;
        logic         rv;
        logic [31:0]  rd;
        logic [102:0] e;
    } vec_t;

    vec_t tbl[$];
    int   npass = 0;
    int   ntot  = 0;

    logic [102:0] act;
    assign act = {instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
                  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
                  avm_read_o, avm_address_o};

    function automatic logic [102:0] pk(
        input int ig, input int iv, input logic [31:0] id, input int ie,
        input int dg, input int dv, input logic [31:0] dd, input int de,
        input int ar, input logic [31:0] aa);
        logic [102:0] r;
        r = {ig[0], iv[0], id, ie[0], dg[0], dv[0], dd, de[0], ar[0], aa};
        return r;
    endfunction

    task automatic add(
        input int ir, input logic [31:0] ia,
        input int dr, input logic [31:0] da, input int dw,
        input int wr, input int rv, input logic [31:0] rd,
        input logic [102:0] e);
        vec_t v;
        v.ir = ir[0];
        v.ia = ia;
        v.dr = dr[0];
        v.da = da;
        v.dw = dw[0];
        v.wr = wr[0];
        v.rv = rv[0];
        v.rd = rd;
        v.e  = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [102:0] e);
        ntot++;
        if (act === e) npass++;
        else $display("FAIL %s got=%h exp=%h", nm, act, e);
    endtask

    task automatic drive(input vec_t v);
        instr_req_i         = v.ir;
        instr_addr_i        = v.ia;
        data_req_i          = v.dr;
        data_addr_i         = v.da;
        data_we_i           = v.dw;
        avm_waitrequest_i   = v.wr;
        avm_readdatavalid_i = v.rv;
        avm_readdata_i      = v.rd;
    endtask

    task automatic cyc(input vec_t v, input string nm);
        drive(v);
        @(negedge IO_CLK);
        check(nm, v.e);
        @(posedge IO_CLK);
        #1;
    endtask

    task automatic cyc1(
        input int ir, input logic [31:0] ia,
        input int dr, input logic [31:0] da,
        input int rv, input logic [31:0] rd,
        input logic [102:0] e, input string nm);
        vec_t v;
        v.ir = ir[0];
        v.ia = ia;
        v.dr = dr[0];
        v.da = da;
        v.dw = 1'b0;
        v.wr = 1'b0;
        v.rv = rv[0];
        v.rd = rd;
        v.e  = e;
        cyc(v, nm);
    endtask

    localparam logic [31:0] I1 = 32'h4000_0010;
    localparam logic [31:0] D1 = 32'h8000_0010;
    localparam logic [31:0] Q  = 32'h0403_0201;

    initial begin
        vec_t z;
        // round-robin pair, instr wins the first tie after reset
        add(1,32'h100,1,32'h200,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(1,0,0,0,0,0,0,0,1,32'h40));
        add(0,0,1,32'h200,0,0,1,32'h1000_0040, pk(0,0,0,0,0,0,0,0,0,32'h40));
        add(0,0,1,32'h200,0,0,0,0, pk(0,1,I1,0,0,0,0,0,0,32'h40));
        add(1,32'h100,1,32'h200,0,0,1,32'hDEAD_BEEF, pk(0,0,I1,0,0,0,0,0,0,32'h40));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(0,0,I1,0,1,0,0,0,1,32'h80));
        add(1,32'h100,0,0,0,0,1,32'h1000_0080, pk(0,0,I1,0,0,0,0,0,0,32'h80));
        add(1,32'h100,0,0,0,0,0,0, pk(0,0,I1,0,0,1,D1,0,0,32'h80));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(0,0,I1,0,0,0,D1,0,0,32'h80));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(1,0,I1,0,0,0,D1,0,1,32'h40));
        add(0,0,1,32'h200,0,0,1,32'h1000_0040, pk(0,0,I1,0,0,0,D1,0,0,32'h40));
        add(0,0,1,32'h200,0,0,0,0, pk(0,1,I1,0,0,0,D1,0,0,32'h40));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(0,0,I1,0,0,0,D1,0,0,32'h40));
        add(1,32'h100,1,32'h200,0,0,0,0, pk(0,0,I1,0,1,0,D1,0,1,32'h80));
        add(0,0,0,0,0,0,1,32'h1000_0080, pk(0,0,I1,0,0,0,D1,0,0,32'h80));
        add(0,0,0,0,0,0,0,0, pk(0,0,I1,0,0,1,D1,0,0,32'h80));
        // minimum-latency instr read with byte swap
        add(1,32'h80,0,0,0,0,0,0, pk(0,0,I1,0,0,0,D1,0,0,32'h80));
        add(1,32'h80,0,0,0,0,0,0, pk(1,0,I1,0,0,0,D1,0,1,32'h20));
        add(0,0,0,0,0,0,1,32'h1122_3344, pk(0,0,I1,0,0,0,D1,0,0,32'h20));
        add(0,0,0,0,0,0,0,0, pk(0,1,32'h4433_2211,0,0,0,D1,0,0,32'h20));
        // waitrequest held for three CMD cycles
        add(1,32'h10,0,0,0,0,0,0, pk(0,0,32'h4433_2211,0,0,0,D1,0,0,32'h20));
        add(1,32'h10,0,0,0,1,0,0, pk(0,0,32'h4433_2211,0,0,0,D1,0,1,32'h4));
        add(1,32'h10,0,0,0,1,0,0, pk(0,0,32'h4433_2211,0,0,0,D1,0,1,32'h4));
        add(1,32'h10,0,0,0,1,0,0, pk(0,0,32'h4433_2211,0,0,0,D1,0,1,32'h4));
        add(1,32'h10,0,0,0,0,0,0, pk(1,0,32'h4433_2211,0,0,0,D1,0,1,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,0,32'h4433_2211,0,0,0,D1,0,0,32'h4));
        add(0,0,0,0,0,0,1,32'h0102_0304, pk(0,0,32'h4433_2211,0,0,0,D1,0,0,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,1,Q,0,0,0,D1,0,0,32'h4));
        // LSU write and out-of-window read error out without a command
        add(0,0,1,32'h4,1,0,0,0, pk(0,0,Q,0,1,0,D1,0,0,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,0,Q,0,0,1,0,1,0,32'h4));
        add(0,0,1,32'h0001_0000,0,0,0,0, pk(0,0,Q,0,1,0,0,1,0,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,0,Q,0,0,1,0,1,0,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,0,Q,0,0,0,0,1,0,32'h4));
        // req dropped in CMD: no gnt, response still returns
        add(1,32'h80,0,0,0,0,0,0, pk(0,0,Q,0,0,0,0,1,0,32'h4));
        add(0,0,0,0,0,0,0,0, pk(0,0,Q,0,0,0,0,1,1,32'h20));
        add(0,0,0,0,0,0,1,32'h5566_7788, pk(0,0,Q,0,0,0,0,1,0,32'h20));
        add(0,0,0,0,0,0,0,0, pk(0,1,32'h8877_6655,0,0,0,0,1,0,32'h20));
        // instr out-of-window error
        add(1,32'h0002_0000,0,0,0,0,0,0, pk(1,0,32'h8877_6655,0,0,0,0,1,0,32'h20));
        add(0,0,0,0,0,0,0,0, pk(0,1,0,1,0,0,0,1,0,32'h20));

        z = tbl[0];
        z.ir = 1'b0;
        z.dr = 1'b0;
        drive(z);
        IO_RST_N = 1'b0;
        @(negedge IO_CLK);
        check("reset", pk(0,0,0,0,0,0,0,0,0,0));
        @(posedge IO_CLK);
        #1;
        IO_RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i], $sformatf("row%0d", i));

        // reset asserted while waiting in DATA
        cyc1(1,32'h80,0,0,0,0, pk(0,0,0,1,0,0,0,1,0,32'h20), "rst_idle");
        cyc1(1,32'h80,0,0,0,0, pk(1,0,0,1,0,0,0,1,1,32'h20), "rst_cmd");
        instr_req_i = 1'b0;
        #2;
        IO_RST_N = 1'b0;
        #1;
        check("rst_async", pk(0,0,0,0,0,0,0,0,0,0));
        @(negedge IO_CLK);
        check("rst_hold", pk(0,0,0,0,0,0,0,0,0,0));
        @(posedge IO_CLK);
        #1;
        IO_RST_N = 1'b1;
        cyc1(0,0,0,0,1,32'h9999_9999, pk(0,0,0,0,0,0,0,0,0,0), "stray_rdv");
        cyc1(0,0,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0), "stray_none");
        cyc1(1,32'h80,1,32'h200,0,0, pk(0,0,0,0,0,0,0,0,0,0), "post_idle");
        cyc1(1,32'h80,1,32'h200,0,0, pk(1,0,0,0,0,0,0,0,1,32'h20), "post_cmd");
        cyc1(0,0,1,32'h200,1,32'hCAFE_F00D, pk(0,0,0,0,0,0,0,0,0,32'h20), "post_data");
        cyc1(0,0,0,0,0,0, pk(0,1,32'h0DF0_FECA,0,0,0,0,0,0,32'h20), "post_resp");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
